// File: rtl/instruction_cache_controller.sv
// Direct-mapped, read-only instruction cache between the fetch stage and a 128-bit block memory.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache_controller #(
  parameter int unsigned INDEX_BITS     = 3,
  parameter logic [27:0] RESET_MEM_ADDR = 28'd0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          READ,
  input  logic [31:0]   ADDRESS,
  output logic [31:0]   INSTRUCTION,
  output logic          BUSYWAIT,
  output logic          MEM_READ,
  output logic [27:0]   MEM_ADDRESS,
  input  logic [127:0]  MEM_READDATA,
`ifdef ICACHE_STATS_EN
  input  logic          MEM_BUSYWAIT,
  output logic [15:0]   HIT_COUNT,
  output logic [15:0]   MISS_COUNT
`else
  input  logic          MEM_BUSYWAIT
`endif
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM_READ, ST_UPDATE} state_t;
  typedef logic [3:0][31:0] block_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  block_t                r_data [LINES];
  logic [TAG_BITS-1:0]   r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_index;
  block_t                r_fill_data;
  logic                  r_first_cycle;

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_capture;
  logic                  w_unused_addr;

  assign w_offset      = ADDRESS[3:2];
  assign w_index       = ADDRESS[3+INDEX_BITS:4];
  assign w_tag         = ADDRESS[31:4+INDEX_BITS];
  assign w_unused_addr = ^ADDRESS[1:0];

  assign w_hit  = (r_state == ST_IDLE) && READ && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss = (r_state == ST_IDLE) && READ && !w_hit;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    BUSYWAIT     = 1'b0;
    MEM_READ     = 1'b0;
    MEM_ADDRESS  = RESET_MEM_ADDR;
    INSTRUCTION  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          BUSYWAIT     = 1'b1;
          w_next_state = ST_MEM_READ;
        end
        if (w_hit) INSTRUCTION = r_data[w_index][w_offset];
      end
      ST_MEM_READ: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_miss_tag, r_miss_index};
        // Memory needs one edge to raise its busy flag, so the entry cycle is not trusted.
        if (!r_first_cycle && !MEM_BUSYWAIT) begin
          w_capture    = 1'b1;
          w_next_state = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        BUSYWAIT     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (RESET) BUSYWAIT = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_first_cycle <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_first_cycle <= w_miss;
      if (r_state == ST_UPDATE) r_valid[r_miss_index] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone decide whether a line is used.
  always_ff @(posedge CLK) begin
    if (w_miss) begin
      r_miss_tag   <= w_tag;
      r_miss_index <= w_index;
    end
    if (w_capture) r_fill_data <= MEM_READDATA;
    if (r_state == ST_UPDATE) begin
      r_tag[r_miss_index]  <= r_miss_tag;
      r_data[r_miss_index] <= r_fill_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hit_count  <= 16'h0;
      r_miss_count <= 16'h0;
    end else begin
      if (w_hit && (r_hit_count != 16'hFFFF))   r_hit_count  <= r_hit_count + 16'h1;
      if (w_miss && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'h1;
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for instruction_cache_controller: fetch stimulus pushes expected words,
// a negedge monitor pops and compares whenever the cache delivers an instruction.
module tb_instruction_cache_controller;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read = 1'b0;
  logic [31:0]   address = 32'h0;
  logic [31:0]   instruction;
  logic          busywait;
  logic          mem_read;
  logic [27:0]   mem_address;
  logic [3:0][31:0] mem_rdata;
  logic          mem_busy = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  instruction_cache_controller dut (
    .CLK          (clk),
    .RESET        (rst),
    .READ         (read),
    .ADDRESS      (address),
    .INSTRUCTION  (instruction),
    .BUSYWAIT     (busywait),
    .MEM_READ     (mem_read),
    .MEM_ADDRESS  (mem_address),
    .MEM_READDATA (mem_rdata),
`ifdef ICACHE_STATS_EN
    .MEM_BUSYWAIT (mem_busy),
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`else
    .MEM_BUSYWAIT (mem_busy)
`endif
  );

  // Memory model: raises busy one edge after seeing MEM_READ, holds it for mem_busy_cycles,
  // then presents block data (word i of block B = B*4 + i) until MEM_READ drops.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_cnt = 0;
  int      mem_busy_cycles = 5;

  always @(posedge clk) begin
    if (rst) begin
      m_state  <= M_IDLE;
      mem_busy <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (mem_read) begin
          m_state  <= M_BUSY;
          mem_busy <= 1'b1;
          m_cnt    <= mem_busy_cycles;
        end
        M_BUSY: if (m_cnt <= 1) begin
          m_state  <= M_DONE;
          mem_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        M_DONE: if (!mem_read) m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_rdata[i] = (m_state == M_DONE) ? {2'b00, mem_address, 2'(i)} : 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivered instruction is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && read && !busywait) begin
      if (exp_q.size() == 0) begin
        check("unexpected delivery (queue size)", 32'd1, 32'd0);
      end else begin
        check("instruction", instruction, exp_q.pop_front());
      end
    end
  end

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp_instr,
                       input int exp_stall, input int exp_mreads, input logic [27:0] exp_maddr);
    int         stall = 0;
    int         mreads = 0;
    int         bad_instr = 0;
    bit         seen = 1'b0;
    logic [27:0] maddr = '0;
    @(posedge clk);
    #1;
    read    = 1'b1;
    address = addr;
    exp_q.push_back(exp_instr);
    forever begin
      @(negedge clk);
      if (!busywait) break;
      stall++;
      if (instruction !== 32'h0) bad_instr++;
      if (mem_read) begin
        mreads++;
        if (!seen) begin
          maddr = mem_address;
          seen  = 1'b1;
        end
      end
      if (stall > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s timeout: busywait still high after %0d cycles", name, stall);
        break;
      end
    end
    check({name, " stall cycles"}, 32'(stall), 32'(exp_stall));
    check({name, " mem_read cycles"}, 32'(mreads), 32'(exp_mreads));
    check({name, " mem_read at delivery"}, {31'h0, mem_read}, 32'h0);
    if (exp_mreads > 0) check({name, " mem_address"}, {4'h0, maddr}, {4'h0, exp_maddr});
    if (exp_stall > 0) check({name, " instruction zero while stalled"}, 32'(bad_instr), 32'h0);
  endtask

  initial begin
    int bad;

    // Reset for two edges with a pending request: no stall, no traffic.
    rst     = 1'b1;
    read    = 1'b1;
    address = 32'h4;
    @(posedge clk);
    @(negedge clk);
    check("reset busywait", {31'h0, busywait}, 32'h0);
    check("reset mem_read", {31'h0, mem_read}, 32'h0);
    check("reset mem_address", {4'h0, mem_address}, 32'h0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    read = 1'b0;

    // Cold miss with 5 busy cycles: stall = 5 + 4, MEM_READ held for 5 + 2 cycles.
    mem_busy_cycles = 5;
    fetch("cold 0x4", 32'h0000_0004, 32'h0000_0001, 9, 7, 28'h0000000);
    fetch("hit 0x0",  32'h0000_0000, 32'h0000_0000, 0, 0, 28'h0);
    fetch("hit 0x8",  32'h0000_0008, 32'h0000_0002, 0, 0, 28'h0);
    fetch("hit 0xC",  32'h0000_000C, 32'h0000_0003, 0, 0, 28'h0);
    @(posedge clk);
    #1;
    read = 1'b0;
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    check("stats miss_count", {16'h0, miss_count}, 32'd1);
    check("stats hit_count", {16'h0, hit_count}, 32'd4);
`endif

    // Idle: no requests, no stall, no memory traffic.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_read || busywait) bad++;
    end
    check("idle activity cycles", 32'(bad), 32'h0);

    // Conflict and index isolation with 2 busy cycles: stall = 6, MEM_READ for 4.
    mem_busy_cycles = 2;
    fetch("conflict 0x80",  32'h0000_0080, 32'h0000_0020, 6, 4, 28'h0000008);
    fetch("refetch 0x0",    32'h0000_0000, 32'h0000_0000, 6, 4, 28'h0000000);
    fetch("index1 0x14",    32'h0000_0014, 32'h0000_0005, 6, 4, 28'h0000001);
    fetch("index0 kept 0xC",32'h0000_000C, 32'h0000_0003, 0, 0, 28'h0);
    fetch("top 0xFFFFFFFC", 32'hFFFF_FFFC, 32'h3FFF_FFFF, 6, 4, 28'hFFFFFFF);
    fetch("top hit 0xFFFFFFF0", 32'hFFFF_FFF0, 32'h3FFF_FFFC, 0, 0, 28'h0);
    @(posedge clk);
    #1;
    read = 1'b0;

    // Reset in the third MEM_READ cycle of a miss on 0x40.
    mem_busy_cycles = 5;
    @(posedge clk);
    #1;
    read    = 1'b1;
    address = 32'h0000_0040;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid-miss mem_read", {31'h0, mem_read}, 32'h1);
    check("mid-miss mem_address", {4'h0, mem_address}, 32'h4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset held busywait", {31'h0, busywait}, 32'h0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    read = 1'b0;
    @(negedge clk);
    check("after reset mem_read", {31'h0, mem_read}, 32'h0);
    check("after reset busywait", {31'h0, busywait}, 32'h0);
    check("after reset mem_address", {4'h0, mem_address}, 32'h0);
    fetch("after reset 0x40", 32'h0000_0040, 32'h0000_0010, 9, 7, 28'h0000004);
    fetch("after reset 0x8",  32'h0000_0008, 32'h0000_0002, 9, 7, 28'h0000000);
    @(posedge clk);
    #1;
    read = 1'b0;

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
